// File: rtl/logic_delay_fanout.sv
// Selectable 2-input gate feeding a DEPTH-stage delay line, tapped per channel at programmable depth.
// Tap t lags f by t+1 enabled edges; config accepts at most one write every 2 cycles (ready drops while BUSY).
module logic_delay_fanout #(
  parameter int NCH   = 3,
  parameter int DEPTH = 8,
  parameter int TAPW  = $clog2(DEPTH),
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            a,
  input  logic            b,
  input  logic [2:0]      func,
  input  logic            flush,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [TAPW-1:0] cfg_tap,
  output logic            cfg_err,
  output logic [NCH-1:0]  out_valid,
  output logic [NCH-1:0]  out
);

  localparam logic [TAPW:0] FILL_MAX = (TAPW + 1)'(DEPTH);
  localparam logic [CHW:0]  NCH_L    = (CHW + 1)'(NCH);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DEPTH-1:0]  r_line;
  logic [TAPW:0]     r_fill;
  logic [TAPW-1:0]   r_tap [NCH];
  logic              r_cfg_err;
  logic              w_f;
  logic              w_cfg_ready;
  logic              w_xfer;
  logic              w_ch_ok;
  logic [NCH-1:0]    w_out_valid;
  logic [NCH-1:0]    w_out;

  always_comb begin
    w_f = 1'b0;
    case (func)
      3'b000:  w_f = ~(a & b);
      3'b001:  w_f = a & b;
      3'b010:  w_f = a | b;
      3'b011:  w_f = ~(a | b);
      3'b100:  w_f = a ^ b;
      3'b101:  w_f = ~(a ^ b);
      3'b110:  w_f = a;
      default: w_f = ~a;
    endcase
  end

  // Flush wins over shift and also blocks capture of f on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_fill <= '0;
    end else if (flush) begin
      r_line <= '0;
      r_fill <= '0;
    end else if (ena) begin
      r_line <= {r_line[DEPTH-2:0], w_f};
      if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cfg_valid) w_state_nxt = S_BUSY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_ready = (r_state == S_IDLE);
  end

  assign w_xfer  = cfg_valid & w_cfg_ready;
  assign w_ch_ok = ({1'b0, cfg_ch} < NCH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
      for (int c = 0; c < NCH; c++) r_tap[c] <= '0;
    end else begin
      r_cfg_err <= w_xfer & ~w_ch_ok;
      for (int c = 0; c < NCH; c++) begin
        if (w_xfer && w_ch_ok && (cfg_ch == CHW'(c))) r_tap[c] <= cfg_tap;
      end
    end
  end

  // Stages not yet written since reset/flush are masked so stale data never escapes.
  always_comb begin
    w_out_valid = '0;
    w_out       = '0;
    for (int c = 0; c < NCH; c++) begin
      w_out_valid[c] = (r_fill > {1'b0, r_tap[c]});
      w_out[c]       = w_out_valid[c] & r_line[r_tap[c]];
    end
  end

  assign cfg_ready = w_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign out_valid = w_out_valid;
  assign out       = w_out;

endmodule

// File: tb/tb_logic_delay_fanout.sv
// Randomized and directed bench for logic_delay_fanout against a queue-based history model.
module tb_logic_delay_fanout;
  localparam int NCH   = 3;
  localparam int DEPTH = 8;
  localparam int TAPW  = 3;
  localparam int CHW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            a = 1'b0;
  logic            b = 1'b0;
  logic [2:0]      func = 3'd0;
  logic            flush = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [TAPW-1:0] cfg_tap = '0;
  logic            cfg_ready;
  logic            cfg_err;
  logic [NCH-1:0]  out_valid;
  logic [NCH-1:0]  out;

  logic_delay_fanout #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a(a), .b(b), .func(func), .flush(flush),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
    .cfg_err(cfg_err), .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: hist holds captured f values, newest first; its size is the fill level.
  bit hist[$];
  int taps[NCH];
  bit m_ready;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_f(input logic [2:0] fn, input bit x, input bit y);
    case (fn)
      3'd0:    return !(x && y);
      3'd1:    return x && y;
      3'd2:    return x || y;
      3'd3:    return !(x || y);
      3'd4:    return x ^ y;
      3'd5:    return !(x ^ y);
      3'd6:    return x;
      default: return !x;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int c = 0; c < NCH; c++) taps[c] = 0;
    m_ready = 1'b1;
    m_err   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] ev;
    logic [NCH-1:0] eo;
    for (int c = 0; c < NCH; c++) begin
      ev[c] = (hist.size() > taps[c]);
      eo[c] = ev[c] ? hist[taps[c]] : 1'b0;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out"},       32'(out),       32'(eo));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(m_ready));
    chk({tag, ".cfg_err"},   32'(cfg_err),   32'(m_err));
  endtask

  // One clock edge: model advances with the inputs present at the edge, then all outputs are compared.
  task automatic tick(input string tag);
    bit f;
    bit xfer;
    f    = ref_f(func, a, b);
    xfer = cfg_valid && m_ready;
    @(posedge clk);
    #1;
    if (flush) hist.delete();
    else if (ena) begin
      hist.push_front(f);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    m_err = xfer && (int'(cfg_ch) >= NCH);
    if (xfer && int'(cfg_ch) < NCH) taps[cfg_ch] = int'(cfg_tap);
    m_ready = !xfer;
    check_all(tag);
  endtask

  task automatic cfg_write(input int ch, input int tap);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_tap   = TAPW'(tap);
    tick("cfg_xfer");
    cfg_valid = 1'b0;
    chk("cfg_busy_ready", 32'(cfg_ready), 32'd0);
    tick("cfg_idle");
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Fill with NAND(1,1)=0, all taps 0.
    ena = 1'b1; a = 1'b1; b = 1'b1; func = 3'd0;
    tick("fill1");
    chk("fill1_valid_const", 32'(out_valid), 32'b111);
    chk("fill1_out_const",   32'(out),       32'b000);
    for (int i = 0; i < DEPTH + 1; i++) tick("fill");

    cfg_write(0, 3);
    cfg_write(1, 5);
    cfg_write(2, 7);

    // Single-cycle pulse travelling to taps 3/5/7.
    flush = 1'b1;
    tick("flush");
    flush = 1'b0; func = 3'd6; a = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick("pulse");
      a = 1'b0;
      chk("pulse_out0", 32'(out[0]), 32'(e == 4));
      chk("pulse_out1", 32'(out[1]), 32'(e == 6));
      chk("pulse_out2", 32'(out[2]), 32'(e == 8));
    end

    cfg_write(0, 0);
    for (int fn = 0; fn < 8; fn++) begin
      for (int ab = 0; ab < 4; ab++) begin
        func = 3'(fn); a = ab[1]; b = ab[0];
        tick("truth");
        chk("truth_out0", 32'(out[0]), 32'(ref_f(3'(fn), ab[1], ab[0])));
      end
    end

    // 10110 pattern with two ena-low cycles interleaved, observed on tap 4.
    cfg_write(1, 4);
    func = 3'd6;
    begin
      logic [4:0] pat;
      logic [6:0] en_seq;
      int pi;
      pat = 5'b10110; en_seq = 7'b1011011; pi = 4;
      for (int k = 6; k >= 0; k--) begin
        ena = en_seq[k];
        if (ena && pi >= 0) begin a = pat[pi]; pi--; end
        tick("ena_pat");
      end
      ena = 1'b1; a = 1'b0;
      for (int k = 0; k < 6; k++) tick("ena_tail");
    end

    // Out-of-range channel, then valid held across BUSY.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_tap = 3'd5;
    tick("err_xfer");
    chk("err_pulse", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    tick("err_after");
    chk("err_clear", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_tap = 3'd2;
    tick("hold1");
    cfg_tap = 3'd6;
    tick("hold2");
    cfg_valid = 1'b0;
    tick("hold3");

    for (int i = 0; i < 600; i++) begin
      ena       = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      a         = 1'($urandom);
      b         = 1'($urandom);
      func      = 3'($urandom);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 2'($urandom);
      cfg_tap   = 3'($urandom);
      tick("rand");
    end

    // Async reset mid-cycle with a config write pending.
    flush = 1'b0; ena = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_tap = 3'd1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    chk("areset_out",   32'(out),       32'd0);
    chk("areset_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cfg_valid = 1'b0; func = 3'd6; a = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
